alu_cmd_sequencer: RTL and testbench

Byte-serial command front-end that drives the 8-bit ALU from the Tiny Tapeout pin interface. It collects an opcode byte and full 8-bit A and B operands over the `ui_in` bus using a strobe handshake. It then issues one operation to an embedded `alu_8bit`, registers the result and flags, and holds them on the output pins until the next command. It is the top-level sequential driver that supplies operands to the combinational ALU.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_8bit.sv | 37 +++
 rtl/strobe_sync.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcode selects, state codes, uio bit map.
package alu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned STATE_W = 3;

    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_AND = 3'b001;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b010;
    localparam logic [SEL_W-1:0] OP_SHL = 3'b011;
    localparam logic [SEL_W-1:0] OP_SHR = 3'b100;

    localparam int unsigned ACC_BIT = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] LOAD_A = 3'd1;
    localparam logic [STATE_W-1:0] LOAD_B = 3'd2;
    localparam logic [STATE_W-1:0] EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] DONE   = 3'd4;

    localparam int unsigned UIO_STB   = 0;
    localparam int unsigned UIO_ABORT = 1;
    localparam int unsigned UIO_BUSY  = 2;
    localparam int unsigned UIO_DONE  = 3;
    localparam int unsigned UIO_ZERO  = 4;
    localparam int unsigned UIO_NEG   = 5;
    localparam int unsigned UIO_CARRY = 6;

    localparam logic [DATA_W-1:0] UIO_OE_MASK = 8'b1111_1100;

    // Loading operands or executing counts as busy.
    function automatic logic is_busy(input logic [STATE_W-1:0] s);
        return (s == LOAD_A) || (s == LOAD_B) || (s == EXEC);
    endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: add/and/or/shift-left/shift-right with zero, negative and carry flags.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [SEL_W-1:0]  SEL,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO,
    output logic              NEGATIVE,
    output logic              CARRY
);

    logic [DATA_W:0] sum;

    // Carry is only meaningful for the adder; every other operation reports 0.
    always_comb begin
        sum    = {1'b0, A} + {1'b0, B};
        RESULT = '0;
        CARRY  = 1'b0;
        case (SEL)
            OP_ADD: begin
                RESULT = sum[DATA_W-1:0];
                CARRY  = sum[DATA_W];
            end
            OP_AND:  RESULT = A & B;
            OP_OR:   RESULT = A | B;
            OP_SHL:  RESULT = {A[DATA_W-2:0], 1'b0};
            OP_SHR:  RESULT = {1'b0, A[DATA_W-1:1]};
            default: RESULT = '0;
        endcase
    end

    assign ZERO     = (RESULT == '0);
    assign NEGATIVE = RESULT[DATA_W-1];

endmodule

// File: rtl/strobe_sync.sv
// Two-flop synchronizer; with EDGE_OUT set, a third flop turns the output into a rising-edge pulse.
module strobe_sync #(
    parameter bit EDGE_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_c
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
        end
    end

    generate
        if (EDGE_OUT) begin : g_edge
            logic s3;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s3 <= 1'b0;
                else        s3 <= s2;
            end
            assign sync_c = s2 & ~s3;
        end else begin : g_level
            assign sync_c = s2;
        end
    endgenerate

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial opcode/A/B loader driving alu_8bit; result and flags held on the pins until the next command.
// Optional ALU_ACCUM_EN: opcode bit 3 reuses the current result as A and skips the A byte.
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] ui_in,
    input  logic [DATA_W-1:0] uio_in,
    output logic [DATA_W-1:0] uo_out,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe
);

    logic               stb_edge;
    logic               abort;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  opcode;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  result;
    logic               flag_zero;
    logic               flag_neg;
    logic               flag_carry;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;
    logic               alu_neg;
    logic               alu_carry;
    logic               unused_bits;

    strobe_sync #(.EDGE_OUT(1'b1)) u_stb_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (uio_in[UIO_STB]),
        .sync_c   (stb_edge)
    );

    strobe_sync #(.EDGE_OUT(1'b0)) u_abort_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (uio_in[UIO_ABORT]),
        .sync_c   (abort)
    );

    alu_8bit u_alu (
        .A        (op_a),
        .B        (op_b),
        .SEL      (opcode[SEL_W-1:0]),
        .RESULT   (alu_result),
        .ZERO     (alu_zero),
        .NEGATIVE (alu_neg),
        .CARRY    (alu_carry)
    );

    // State register; busy/done are registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= is_busy(state_next);
            done  <= (state_next == DONE);
        end
    end

    // Next-state logic; abort outranks a coincident strobe edge, ena low freezes everything.
    always_comb begin
        state_next = state;
        if (ena) begin
            if (abort) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (stb_edge) begin
`ifdef ALU_ACCUM_EN
                            state_next = ui_in[ACC_BIT] ? LOAD_B : LOAD_A;
`else
                            state_next = LOAD_A;
`endif
                        end
                    end
                    LOAD_A:  if (stb_edge) state_next = LOAD_B;
                    LOAD_B:  if (stb_edge) state_next = EXEC;
                    EXEC:    state_next = DONE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Opcode/operand capture and result/flag latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_neg   <= 1'b0;
            flag_carry <= 1'b0;
        end else if (ena) begin
            if (abort) begin
                opcode <= '0;
                op_a   <= '0;
                op_b   <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (stb_edge) begin
                            opcode <= ui_in;
`ifdef ALU_ACCUM_EN
                            if (ui_in[ACC_BIT]) op_a <= result;
`endif
                        end
                    end
                    LOAD_A: if (stb_edge) op_a <= ui_in;
                    LOAD_B: if (stb_edge) op_b <= ui_in;
                    EXEC: begin
                        result     <= alu_result;
                        flag_zero  <= alu_zero;
                        flag_neg   <= alu_neg;
                        flag_carry <= alu_carry;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        uio_out            = '0;
        uio_out[UIO_BUSY]  = busy;
        uio_out[UIO_DONE]  = done;
        uio_out[UIO_ZERO]  = flag_zero;
        uio_out[UIO_NEG]   = flag_neg;
        uio_out[UIO_CARRY] = flag_carry;
    end

    assign uo_out = result;
    assign uio_oe = UIO_OE_MASK;

    assign unused_bits = &{1'b0, uio_in[DATA_W-1:2], opcode[DATA_W-1:SEL_W]};

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer (default build; ALU_ACCUM_EN changes one expectation).
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests  = 0;
    int failed = 0;

    alu_cmd_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise strobe with a byte; returns #1 after the capture edge (third rising edge).
    task automatic stb_rise(input logic [7:0] b);
        @(negedge clk);
        ui_in     = b;
        uio_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic stb_fall();
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        stb_rise(b);
        stb_fall();
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send(op);
        send(a);
        send(b);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'hFC);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry, exact latency around the B capture
        send(8'h00);
        chk("add_busy_after_op", uio_out, 8'h04);
        send(8'hF0);
        stb_rise(8'h20);
        chk("add_exec_uio", uio_out, 8'h04);
        chk("add_exec_uo_held", uo_out, 8'h00);
        @(posedge clk);
        #1;
        chk("add_result", uo_out, 8'h10);
        chk("add_flags_done", uio_out, 8'h48);
        stb_fall();

        // Reset in the middle of loading
        send(8'h01);
        send(8'h0F);
        chk("midload_busy", uio_out, 8'h44);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midload_rst_uo", uo_out, 8'h00);
        chk("midload_rst_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // AND giving zero; prior result held until EXEC
        run_cmd(8'h00, 8'hF0, 8'h20);
        chk("add2_result", uo_out, 8'h10);
        send(8'h01);
        chk("and_op_done_falls", uio_out, 8'h44);
        send(8'h0F);
        stb_rise(8'hF0);
        chk("and_exec_uo_held", uo_out, 8'h10);
        stb_fall();
        chk("and_result", uo_out, 8'h00);
        chk("and_flags", uio_out, 8'h18);

        run_cmd(8'h03, 8'hC1, 8'h00);
        chk("shl_result", uo_out, 8'h82);
        chk("shl_flags", uio_out, 8'h28);

        run_cmd(8'h02, 8'h12, 8'h21);
        chk("or_result", uo_out, 8'h33);
        chk("or_flags", uio_out, 8'h08);

        run_cmd(8'h06, 8'hAA, 8'h55);
        chk("op6_result", uo_out, 8'h00);
        chk("op6_flags", uio_out, 8'h18);

        run_cmd(8'h04, 8'h81, 8'h00);
        chk("shr_result", uo_out, 8'h40);
        chk("shr_flags", uio_out, 8'h08);

        // Abort after A byte: idle, result kept, partial operands dropped
        send(8'h00);
        send(8'h01);
        chk("abort_pre_busy", uio_out, 8'h04);
        @(negedge clk);
        uio_in[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_uio", uio_out, 8'h00);
        chk("abort_uo_kept", uo_out, 8'h40);
        @(negedge clk);
        uio_in[1] = 1'b0;
        repeat (3) @(posedge clk);
        run_cmd(8'h00, 8'h01, 8'h02);
        chk("post_abort_result", uo_out, 8'h03);
        chk("post_abort_flags", uio_out, 8'h08);

        // Abort coincident with a strobe edge wins
        @(negedge clk);
        ui_in     = 8'h00;
        uio_in[0] = 1'b1;
        uio_in[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_vs_stb_uio", uio_out, 8'h00);
        @(negedge clk);
        uio_in[0] = 1'b0;
        uio_in[1] = 1'b0;
        repeat (3) @(posedge clk);
        run_cmd(8'h00, 8'hF0, 8'h20);
        chk("add3_result", uo_out, 8'h10);
        chk("add3_flags", uio_out, 8'h48);

        // Strobe edge while ena is low is dropped, not queued
        @(negedge clk);
        ena = 1'b0;
        send(8'h01);
        chk("ena_low_hold", uio_out, 8'h48);
        @(negedge clk);
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ena_no_queue", uio_out, 8'h48);
        chk("ena_uo", uo_out, 8'h10);

        // Accumulator opcode: two strobes
        send(8'h08);
        send(8'h05);
`ifdef ALU_ACCUM_EN
        chk("accum_result", uo_out, 8'h15);
        chk("accum_flags", uio_out, 8'h08);
`else
        chk("noaccum_uo", uo_out, 8'h10);
        chk("noaccum_wait_b", uio_out, 8'h44);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
